// File: rtl/rv_lsu_pkg.sv
// rtl/rv_lsu_pkg.sv - shared types, codes and command checks for the load/store unit
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic f3_legal(input logic load, input logic [2:0] f3, input logic wide);
    if (load)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU) ||
             (wide && ((f3 == F3_D) || (f3 == F3_WU)));
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (wide && (f3 == F3_D));
  endfunction

  // size is funct3[1:0]: log2 of the access width in bytes
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return |low;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// rtl/rv_lsu_align.sv - byte-lane strobes, store shifting and load extraction/extension
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  read_data,
  output logic [NB-1:0]    strb,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_data
);

  localparam logic [XLEN-1:0] M8  = XLEN'(8'hFF);
  localparam logic [XLEN-1:0] M16 = XLEN'(16'hFFFF);
  localparam logic [XLEN-1:0] M32 = XLEN'(32'hFFFF_FFFF);

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] rd;

  always_comb begin
    case (funct3[1:0])
      2'd0:    size_mask = NB'(8'h01);
      2'd1:    size_mask = NB'(8'h03);
      2'd2:    size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
  end

  assign strb  = size_mask << offset;
  assign wdata = store_data << {offset, 3'b000};
  assign rd    = read_data >> {offset, 3'b000};

  // Sign extension by masking keeps this width-agnostic for XLEN 32 and 64
  always_comb begin
    case (funct3)
      F3_B:    load_data = rd[7]  ? (rd | ~M8)  : (rd & M8);
      F3_H:    load_data = rd[15] ? (rd | ~M16) : (rd & M16);
      F3_W:    load_data = rd[31] ? (rd | ~M32) : (rd & M32);
      F3_BU:   load_data = rd & M8;
      F3_HU:   load_data = rd & M16;
      F3_WU:   load_data = rd & M32;
      default: load_data = rd;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - single-access load/store unit with command checks and bounded bus wait
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iLoad,
  input  logic [2:0]          iFunct3,
  input  logic [ADDR_W-1:0]   iAddr,
  input  logic [XLEN-1:0]     iStoreData,
  output logic                oBusy,
  output logic                oDone,
  output logic [1:0]          oErr,
  output logic [XLEN-1:0]     oLoadData,
  output logic [ADDR_W-1:0]   oMemAddr,
  output logic [XLEN-1:0]     oMemData,
  output logic [XLEN/8-1:0]   oMemStrb,
  output logic                oMemRead,
  output logic                oMemWrite,
  input  logic [XLEN-1:0]     iMemData,
  input  logic                iMemRdy
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state, state_nx;
  logic                load_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     sdata_q;
  logic [1:0]          err_q, err_nx;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     ld_q;
  logic                legal, mis, timeout_hit;
  logic [NB-1:0]       strb;
  logic [XLEN-1:0]     wdata, ext;

  assign legal       = f3_legal(iLoad, iFunct3, XLEN == 64);
  assign mis         = misaligned(iFunct3[1:0], iAddr[2:0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  rv_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (f3_q),
    .offset     (addr_q[OFF_W-1:0]),
    .store_data (sdata_q),
    .read_data  (iMemData),
    .strb       (strb),
    .wdata      (wdata),
    .load_data  (ext)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nx;
  end

  // Illegal funct3 takes priority over misalignment
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (iStart) begin
          if (!legal) begin
            state_nx = DONE;
            err_nx   = ERR_ILLEGAL;
          end else if (mis) begin
            state_nx = DONE;
            err_nx   = ERR_MISALIGN;
          end else begin
            state_nx = ACCESS;
            err_nx   = ERR_OK;
          end
        end
      end
      ACCESS: begin
        if (iMemRdy) begin
          state_nx = DONE;
          err_nx   = ERR_OK;
        end else if (timeout_hit) begin
          state_nx = DONE;
          err_nx   = ERR_TIMEOUT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      load_q  <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      err_q   <= ERR_OK;
      cnt     <= '0;
      ld_q    <= '0;
    end else begin
      err_q <= err_nx;
      if (state == IDLE && iStart) begin
        load_q  <= iLoad;
        f3_q    <= iFunct3;
        addr_q  <= iAddr;
        sdata_q <= iStoreData;
        cnt     <= '0;
      end
      if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        if (iMemRdy && load_q) ld_q <= ext;
      end
    end
  end

  assign oLoadData = ld_q;

  always_comb begin
    oBusy     = (state != IDLE);
    oDone     = (state == DONE);
    oErr      = (state == DONE) ? err_q : ERR_OK;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oMemAddr  = '0;
    oMemData  = '0;
    oMemStrb  = '0;
    if (state == ACCESS) begin
      oMemRead  = load_q;
      oMemWrite = !load_q;
      oMemAddr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
      oMemStrb  = strb;
      oMemData  = load_q ? '0 : wdata;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - directed vector bench for rv_lsu at XLEN 32 (TIMEOUT 4) and XLEN 64
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 0, load = 0, mrdy = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] addr = 0, sdata = 0, mdata = 0;
  logic        busy, done, mrd, mwr;
  logic [1:0]  err;
  logic [31:0] ldata, maddr, mwdata;
  logic [3:0]  mstrb;

  logic        start64 = 0, load64 = 0, rdy64 = 0;
  logic [2:0]  f3_64 = 0;
  logic [31:0] addr64 = 0;
  logic [63:0] sdata64 = 0, mdata64 = 0;
  logic        busy64, done64, mrd64, mwr64;
  logic [1:0]  err64;
  logic [63:0] ldata64, mwdata64;
  logic [31:0] maddr64;
  logic [7:0]  mstrb64;

  rv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .iClk(clk), .iRst(rst), .iStart(start), .iLoad(load), .iFunct3(f3), .iAddr(addr),
    .iStoreData(sdata), .oBusy(busy), .oDone(done), .oErr(err), .oLoadData(ldata),
    .oMemAddr(maddr), .oMemData(mwdata), .oMemStrb(mstrb), .oMemRead(mrd), .oMemWrite(mwr),
    .iMemData(mdata), .iMemRdy(mrdy)
  );

  rv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
    .iClk(clk), .iRst(rst), .iStart(start64), .iLoad(load64), .iFunct3(f3_64), .iAddr(addr64),
    .iStoreData(sdata64), .oBusy(busy64), .oDone(done64), .oErr(err64), .oLoadData(ldata64),
    .oMemAddr(maddr64), .oMemData(mwdata64), .oMemStrb(mstrb64), .oMemRead(mrd64),
    .oMemWrite(mwr64), .iMemData(mdata64), .iMemRdy(rdy64)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [2:0]  fn;
    logic [31:0] ad;
    logic [31:0] sd;
    logic [31:0] md;
    int          dly;
    int          e_done;
    int          e_rd;
    int          e_wr;
    logic [1:0]  e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
  } vec_t;

  int          r_done, r_rd, r_wr, r_unst;
  logic [1:0]  r_err;
  logic [31:0] r_addr, r_wd, r_ld;
  logic [3:0]  r_strb, r_sany;
  logic        r_idle;

  // dly = wait cycles before iMemRdy; rdy is high in ACCESS cycle dly+1
  task automatic run32(input logic ld, input logic [2:0] fn, input logic [31:0] ad,
                       input logic [31:0] sd, input logic [31:0] md, input int dly,
                       input bit poke);
    bit got;
    got = 0;
    @(negedge clk);
    start = 1; load = ld; f3 = fn; addr = ad; sdata = sd; mdata = md; mrdy = 0;
    r_done = -1; r_rd = 0; r_wr = 0; r_unst = 0; r_err = 0; r_sany = 0;
    r_addr = 0; r_wd = 0; r_strb = 0; r_ld = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = poke;
      if (poke) begin load = 1; f3 = F3_W; addr = 32'h300; end
      mrdy = (c == dly + 1);
      r_sany |= mstrb;
      if (mrd) r_rd++;
      if (mwr) r_wr++;
      if (mrd || mwr) begin
        if (!got) begin
          got = 1; r_addr = maddr; r_wd = mwdata; r_strb = mstrb;
        end else if (maddr !== r_addr || mwdata !== r_wd || mstrb !== r_strb) begin
          r_unst++;
        end
      end
      if (done) begin
        r_done = c; r_err = err; r_ld = ldata;
        start = 0; mrdy = 0;
        break;
      end
    end
    start = 0; mrdy = 0;
    @(negedge clk);
    r_idle = !busy && !mrd && !mwr && !done;
  endtask

  task automatic run64(input logic ld, input logic [2:0] fn, input logic [31:0] ad,
                       input logic [63:0] md, input logic [7:0] e_strb,
                       input logic [63:0] e_ld, input string nm);
    @(negedge clk);
    start64 = 1; load64 = ld; f3_64 = fn; addr64 = ad; mdata64 = md; rdy64 = 0;
    @(negedge clk);
    start64 = 0; rdy64 = 1;
    chk({nm, " read"}, 64'(mrd64), 64'd1);
    chk({nm, " strb"}, 64'(mstrb64), 64'(e_strb));
    chk({nm, " addr"}, 64'(maddr64), 64'({ad[31:3], 3'b000}));
    @(negedge clk);
    rdy64 = 0;
    chk({nm, " done"}, 64'(done64), 64'd1);
    chk({nm, " err"}, 64'(err64), 64'(ERR_OK));
    chk({nm, " ldata"}, ldata64, e_ld);
    @(negedge clk);
  endtask

  vec_t vt[18];

  initial begin
    vt[0]  = '{1'b1, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, ERR_OK, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
    vt[1]  = '{1'b1, F3_B,  32'h103, 32'h0, 32'h80000000, 0, 2, 1, 0, ERR_OK, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
    vt[2]  = '{1'b1, F3_BU, 32'h103, 32'h0, 32'h80000000, 0, 2, 1, 0, ERR_OK, 32'h100, 4'h8, 32'h0, 32'h00000080};
    vt[3]  = '{1'b1, F3_H,  32'h102, 32'h0, 32'h80010000, 0, 2, 1, 0, ERR_OK, 32'h100, 4'hC, 32'h0, 32'hFFFF8001};
    vt[4]  = '{1'b1, F3_HU, 32'h102, 32'h0, 32'h80010000, 0, 2, 1, 0, ERR_OK, 32'h100, 4'hC, 32'h0, 32'h00008001};
    vt[5]  = '{1'b0, F3_H,  32'h202, 32'h0000ABCD, 32'h0, 3, 5, 0, 4, ERR_OK, 32'h200, 4'hC, 32'hABCD0000, 32'h00008001};
    vt[6]  = '{1'b0, F3_B,  32'h201, 32'h12345677, 32'h0, 0, 2, 0, 1, ERR_OK, 32'h200, 4'h2, 32'h34567700, 32'h00008001};
    vt[7]  = '{1'b0, F3_W,  32'h204, 32'hCAFEF00D, 32'h0, 1, 3, 0, 2, ERR_OK, 32'h204, 4'hF, 32'hCAFEF00D, 32'h00008001};
    vt[8]  = '{1'b1, F3_W,  32'h101, 32'h0, 32'h0, 0, 1, 0, 0, ERR_MISALIGN, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[9]  = '{1'b1, F3_H,  32'h103, 32'h0, 32'h0, 0, 1, 0, 0, ERR_MISALIGN, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[10] = '{1'b1, F3_D,  32'h100, 32'h0, 32'h0, 0, 1, 0, 0, ERR_ILLEGAL, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[11] = '{1'b1, F3_D,  32'h101, 32'h0, 32'h0, 0, 1, 0, 0, ERR_ILLEGAL, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[12] = '{1'b1, F3_WU, 32'h100, 32'h0, 32'h0, 0, 1, 0, 0, ERR_ILLEGAL, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[13] = '{1'b0, F3_BU, 32'h200, 32'h0, 32'h0, 0, 1, 0, 0, ERR_ILLEGAL, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vt[14] = '{1'b1, F3_W,  32'h104, 32'h0, 32'h0BADF00D, 100, 5, 4, 0, ERR_TIMEOUT, 32'h104, 4'hF, 32'h0, 32'h00008001};
    vt[15] = '{1'b1, F3_W,  32'h104, 32'h0, 32'h0BADF00D, 3, 5, 4, 0, ERR_OK, 32'h104, 4'hF, 32'h0, 32'h0BADF00D};
    vt[16] = '{1'b1, F3_B,  32'h101, 32'h0, 32'h00007F00, 0, 2, 1, 0, ERR_OK, 32'h100, 4'h2, 32'h0, 32'h0000007F};
    vt[17] = '{1'b1, F3_HU, 32'h100, 32'h0, 32'h1234FFFE, 0, 2, 1, 0, ERR_OK, 32'h100, 4'h3, 32'h0, 32'h0000FFFE};

    #12;
    chk("reset outputs", {28'(0), busy, done, mrd, mwr, err, mstrb, ldata, maddr[15:0], mwdata[15:0]}, 64'd0);
    chk("reset outputs64", {busy64, done64, mrd64, mwr64, err64, mstrb64} , 64'd0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 18; i++) begin
      run32(vt[i].ld, vt[i].fn, vt[i].ad, vt[i].sd, vt[i].md, vt[i].dly, 1'b0);
      chk($sformatf("v%0d done_cycle", i), 64'(r_done), 64'(vt[i].e_done));
      chk($sformatf("v%0d err", i), 64'(r_err), 64'(vt[i].e_err));
      chk($sformatf("v%0d read_cycles", i), 64'(r_rd), 64'(vt[i].e_rd));
      chk($sformatf("v%0d write_cycles", i), 64'(r_wr), 64'(vt[i].e_wr));
      chk($sformatf("v%0d strb_seen", i), 64'(r_sany), 64'(vt[i].e_strb));
      chk($sformatf("v%0d ldata", i), 64'(r_ld), 64'(vt[i].e_ld));
      chk($sformatf("v%0d idle_after", i), 64'(r_idle), 64'd1);
      if (vt[i].e_rd + vt[i].e_wr > 0) begin
        chk($sformatf("v%0d addr", i), 64'(r_addr), 64'(vt[i].e_addr));
        chk($sformatf("v%0d wdata", i), 64'(r_wd), 64'(vt[i].e_wd));
        chk($sformatf("v%0d bus_stable", i), 64'(r_unst), 64'd0);
      end
    end

    // iStart held high through ACCESS and DONE with a different command must be ignored
    run32(1'b1, F3_B, 32'h100, 32'h0, 32'h000000A5, 2, 1'b1);
    chk("poke done_cycle", 64'(r_done), 64'd4);
    chk("poke read_cycles", 64'(r_rd), 64'd3);
    chk("poke addr", 64'(r_addr), 64'h100);
    chk("poke strb", 64'(r_strb), 64'h1);
    chk("poke ldata", 64'(r_ld), 64'hFFFFFFA5);
    chk("poke idle_after", 64'(r_idle), 64'd1);

    run64(1'b1, F3_D,  32'h08, 64'h1122334455667788, 8'hFF, 64'h1122334455667788, "ld64");
    run64(1'b1, F3_WU, 32'h0C, 64'hFFFFFFFF00000000, 8'hF0, 64'h00000000FFFFFFFF, "lwu64");
    run64(1'b1, F3_W,  32'h0C, 64'hFFFFFFFF00000000, 8'hF0, 64'hFFFFFFFFFFFFFFFF, "lw64");

    // Reset in the middle of ACCESS, away from any clock edge
    @(negedge clk);
    start = 1; load = 1; f3 = F3_W; addr = 32'h100; mdata = 32'h0; mrdy = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("pre-reset read", 64'(mrd), 64'd1);
    #2 rst = 1;
    #1;
    chk("async reset read", 64'(mrd), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset strb", 64'(mstrb), 64'd0);
    chk("async reset ldata", 64'(ldata), 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post-reset idle", 64'({busy, mrd, done}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
